// File: rtl/puf_mask_sched_pkg.sv
// Shared types and constants for the PUF keystream-masking sequencer.
// Latency: none (types, constants and an elaboration-time helper only).
// Backpressure: not applicable.
package puf_mask_sched_pkg;

    // Sequencer states, in operation order.
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_RUN     = 3'd2,
        S_CAPTURE = 3'd3,
        S_RESP    = 3'd4
    } state_t;

    // Extra RUN cycles granted beyond a full keystream pass before the watchdog fires.
    localparam int TIMEOUT_OFFSET = 8;

    // Width needed to hold a requester index; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int DEFAULT_NUM_REQ = 2;
    localparam int DEFAULT_IDX_W   = idx_width(DEFAULT_NUM_REQ);

endpackage

// File: rtl/puf_mask_sched_rr_pick.sv
// Round-robin priority picker: first active request after the last granted index.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to act on the pick.
module puf_mask_sched_rr_pick #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = 1
) (
    input  logic [NUM_REQ-1:0] i_Req,
    input  logic [IDX_W-1:0]   i_Last,
    output logic [NUM_REQ-1:0] o_Grant,
    output logic [IDX_W-1:0]   o_Idx,
    output logic               o_Valid
);

    // Walk the indices starting one past the last grant and stop at the first requester.
    always_comb begin
        logic [IDX_W-1:0] pos;
        o_Grant = '0;
        o_Idx   = i_Last;
        o_Valid = 1'b0;
        pos     = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            pos = IDX_W'((int'(i_Last) + i) % NUM_REQ);
            if (!o_Valid && i_Req[pos]) begin
                o_Grant[pos] = 1'b1;
                o_Idx        = pos;
                o_Valid      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/puf_mask_sched.sv
// Arbitrates requesters onto the shared LFSR masking engine and sequences load/run/capture/respond.
// Latency: grant to done is engine run length + 3 cycles; watchdog abort after TIMEOUT RUN cycles.
// Backpressure: requests hold level until o_Done; one operation at a time, no pre-emption.
module puf_mask_sched
    import puf_mask_sched_pkg::*;
#(
    parameter int NUM_REQ     = 2,
    parameter int NUM_BITS    = 32,
    parameter int OUTPUT_SIZE = 256,
    parameter int TIMEOUT     = OUTPUT_SIZE + TIMEOUT_OFFSET
) (
    input  logic                            i_Clk,
    input  logic                            i_Reset,
    input  logic [NUM_REQ-1:0]              i_Req,
    input  logic [NUM_REQ*NUM_BITS-1:0]     i_Seed,
    input  logic [NUM_REQ*OUTPUT_SIZE-1:0]  i_Data,
    output logic [NUM_REQ-1:0]              o_Grant,
    output logic [NUM_REQ-1:0]              o_Done,
    output logic                            o_Error,
    output logic [OUTPUT_SIZE-1:0]          o_Result,
    output logic                            o_Busy,
    output logic                            o_Lfsr_Enable,
    output logic                            o_Lfsr_Load,
    output logic [NUM_BITS-1:0]             o_Lfsr_Seed,
    output logic [OUTPUT_SIZE-1:0]          o_Lfsr_Data_In,
    input  logic [OUTPUT_SIZE-1:0]          i_Lfsr_Data,
    input  logic                            i_Lfsr_Done
);

    localparam int IDX_W = idx_width(NUM_REQ);
    localparam int WD_W  = $clog2(TIMEOUT + 1);

    state_t            r_State;
    state_t            w_Next;
    logic [IDX_W-1:0]  r_Last;
    logic [IDX_W-1:0]  r_Idx;
    logic [WD_W-1:0]   r_Wd;
    logic              r_Err;
    logic [NUM_REQ-1:0] w_Pick_Grant;
    logic [IDX_W-1:0]  w_Pick_Idx;
    logic              w_Pick_Vld;
    logic              w_Timeout;

    puf_mask_sched_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .i_Req   (i_Req),
        .i_Last  (r_Last),
        .o_Grant (w_Pick_Grant),
        .o_Idx   (w_Pick_Idx),
        .o_Valid (w_Pick_Vld)
    );

    assign w_Timeout = (r_Wd == WD_W'(TIMEOUT - 1));

    // State register.
    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) r_State <= S_IDLE;
        else         r_State <= w_Next;
    end

    // Next-state and engine/handshake strobes; a stale done is ignored while loading.
    always_comb begin
        w_Next        = r_State;
        o_Lfsr_Enable = 1'b0;
        o_Lfsr_Load   = 1'b0;
        o_Done        = '0;
        o_Error       = 1'b0;
        o_Busy        = 1'b1;
        case (r_State)
            S_IDLE: begin
                o_Busy = 1'b0;
                if (w_Pick_Vld) w_Next = S_LOAD;
            end
            S_LOAD: begin
                o_Lfsr_Enable = 1'b1;
                o_Lfsr_Load   = 1'b1;
                w_Next        = S_RUN;
            end
            S_RUN: begin
                o_Lfsr_Enable = 1'b1;
                if (i_Lfsr_Done)    w_Next = S_CAPTURE;
                else if (w_Timeout) w_Next = S_RESP;
            end
            S_CAPTURE: w_Next = S_RESP;
            S_RESP: begin
                o_Done  = o_Grant;
                o_Error = r_Err;
                w_Next  = S_IDLE;
            end
            default: w_Next = S_IDLE;
        endcase
    end

    // Grant/operand latch, saturating watchdog, result capture and last-grant bookkeeping.
    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            o_Grant        <= '0;
            o_Result       <= '0;
            o_Lfsr_Seed    <= '0;
            o_Lfsr_Data_In <= '0;
            r_Last         <= IDX_W'(NUM_REQ - 1);
            r_Idx          <= '0;
            r_Wd           <= '0;
            r_Err          <= 1'b0;
        end else begin
            case (r_State)
                S_IDLE: begin
                    if (w_Pick_Vld) begin
                        o_Grant        <= w_Pick_Grant;
                        r_Idx          <= w_Pick_Idx;
                        o_Lfsr_Seed    <= i_Seed[int'(w_Pick_Idx)*NUM_BITS +: NUM_BITS];
                        o_Lfsr_Data_In <= i_Data[int'(w_Pick_Idx)*OUTPUT_SIZE +: OUTPUT_SIZE];
                    end
                end
                S_LOAD: r_Wd <= '0;
                S_RUN: begin
                    if (!i_Lfsr_Done && w_Timeout) r_Err <= 1'b1;
                    if (r_Wd != WD_W'(TIMEOUT)) r_Wd <= r_Wd + WD_W'(1);
                end
                S_CAPTURE: o_Result <= i_Lfsr_Data;
                S_RESP: begin
                    o_Grant <= '0;
                    r_Err   <= 1'b0;
                    r_Last  <= r_Idx;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_puf_mask_sched.sv
// Randomized bench for puf_mask_sched with an engine model and a rule-level scoreboard.
// Latency: checks every cycle of every operation against the sequencing rules.
// Backpressure: requesters hold, drop or re-raise requests at random around done pulses.
module tb_puf_mask_sched;

    localparam int N   = 2;
    localparam int NB  = 32;
    localparam int OS  = 256;
    localparam int TMO = OS + 8;

    logic              clk;
    logic              rst;
    logic [N-1:0]      i_Req;
    logic [N*NB-1:0]   i_Seed;
    logic [N*OS-1:0]   i_Data;
    logic [N-1:0]      o_Grant;
    logic [N-1:0]      o_Done;
    logic              o_Error;
    logic [OS-1:0]     o_Result;
    logic              o_Busy;
    logic              o_Lfsr_Enable;
    logic              o_Lfsr_Load;
    logic [NB-1:0]     o_Lfsr_Seed;
    logic [OS-1:0]     o_Lfsr_Data_In;
    logic [OS-1:0]     i_Lfsr_Data;
    logic              i_Lfsr_Done;

    puf_mask_sched #(
        .NUM_REQ(N), .NUM_BITS(NB), .OUTPUT_SIZE(OS), .TIMEOUT(TMO)
    ) dut (
        .i_Clk(clk), .i_Reset(rst), .i_Req(i_Req), .i_Seed(i_Seed), .i_Data(i_Data),
        .o_Grant(o_Grant), .o_Done(o_Done), .o_Error(o_Error), .o_Result(o_Result),
        .o_Busy(o_Busy), .o_Lfsr_Enable(o_Lfsr_Enable), .o_Lfsr_Load(o_Lfsr_Load),
        .o_Lfsr_Seed(o_Lfsr_Seed), .o_Lfsr_Data_In(o_Lfsr_Data_In),
        .i_Lfsr_Data(i_Lfsr_Data), .i_Lfsr_Done(i_Lfsr_Done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [OS-1:0] got, input logic [OS-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Keystream of a 32-bit Fibonacci LFSR, one output bit per step.
    function automatic logic [OS-1:0] ks(input logic [NB-1:0] seed);
        logic [NB-1:0] s;
        logic [OS-1:0] r;
        s = seed;
        r = '0;
        for (int i = 0; i < OS; i++) begin
            r[i] = s[0];
            s = {s[31] ^ s[21] ^ s[1] ^ s[0], s[31:1]};
        end
        return r;
    endfunction

    function automatic logic [OS-1:0] rnd_blk();
        logic [OS-1:0] r;
        for (int w = 0; w < OS / 32; w++) r[w*32 +: 32] = $urandom;
        return r;
    endfunction

    // Round-robin rule: first requester strictly after the last winner, wrapping.
    function automatic int rr_idx(input logic [N-1:0] req, input int last);
        for (int d = 1; d <= N; d++) if (req[(last + d) % N]) return (last + d) % N;
        return -1;
    endfunction

    // ---------------- engine model: done D enabled cycles after a load, sticky ----------
    int            next_d;
    int            eng_d;
    int            eng_cnt;
    logic          eng_done;
    logic [OS-1:0] eng_res;
    logic [OS-1:0] eng_junk;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            eng_d    <= 1;
            eng_cnt  <= 0;
            eng_done <= 1'b0;
            eng_res  <= '0;
            eng_junk <= '0;
        end else begin
            eng_junk <= rnd_blk();
            if (o_Lfsr_Load) begin
                eng_cnt  <= 0;
                eng_done <= 1'b0;
                eng_d    <= next_d;
                eng_res  <= o_Lfsr_Data_In ^ ks(o_Lfsr_Seed);
            end else if (o_Lfsr_Enable && !eng_done) begin
                eng_cnt <= eng_cnt + 1;
                if (eng_cnt + 1 == eng_d) eng_done <= 1'b1;
            end
        end
    end

    assign i_Lfsr_Done = eng_done;
    assign i_Lfsr_Data = eng_done ? eng_res : eng_junk;

    // ---------------- scoreboard, evaluated mid-cycle ----------------
    // Operation timeline, counted in cycles from the grant cycle (0 = LOAD):
    // success: engine done after D run cycles, seen in cycle D+1, capture D+2, respond D+3;
    // timeout (D >= TMO): RUN cycles 1..TMO, respond at TMO+1 with the result untouched.
    logic [N-1:0]    m_req_s;
    logic [N*NB-1:0] m_seed_s;
    logic [N*OS-1:0] m_data_s;
    int              m_last;
    bit              m_active;
    bit              m_block;
    int              m_cyc;
    int              m_idx;
    logic [N-1:0]    m_gnt;
    logic [NB-1:0]   m_seed;
    logic [OS-1:0]   m_data;
    logic [OS-1:0]   m_exp;
    logic [OS-1:0]   m_last_res;

    always @(negedge clk) begin
        logic [N-1:0] exp_g;
        logic [N-1:0] one;
        bit           err;
        int           run_last;
        int           resp;
        int           w;
        if (rst) begin
            m_last     = N - 1;
            m_active   = 1'b0;
            m_block    = 1'b1;
            m_last_res = '0;
        end else begin
            if (!m_active) begin
                one   = 1;
                w     = m_block ? -1 : rr_idx(m_req_s, m_last);
                exp_g = (w < 0) ? '0 : (one << w);
                chk("grant_pick", o_Grant, exp_g);
                m_block = 1'b0;
                if (w >= 0) begin
                    m_active = 1'b1;
                    m_cyc    = 0;
                    m_idx    = w;
                    m_gnt    = exp_g;
                    m_seed   = m_seed_s[w*NB +: NB];
                    m_data   = m_data_s[w*OS +: OS];
                    m_exp    = ks(m_seed) ^ m_data;
                end
            end
            chk("busy", o_Busy, m_active);
            if (!m_active) begin
                chk("idle_done", o_Done, 0);
                chk("idle_err", o_Error, 0);
                chk("idle_en", o_Lfsr_Enable, 0);
                chk("idle_load", o_Lfsr_Load, 0);
                chk("idle_result", o_Result, m_last_res);
            end else begin
                chk("grant_hold", o_Grant, m_gnt);
                chk("load", o_Lfsr_Load, m_cyc == 0);
                chk("seed_out", o_Lfsr_Seed, m_seed);
                chk("data_out", o_Lfsr_Data_In, m_data);
                if (m_cyc == 0) begin
                    chk("en_load", o_Lfsr_Enable, 1);
                    chk("done_early", o_Done, 0);
                    chk("result_hold", o_Result, m_last_res);
                end else begin
                    err      = (eng_d >= TMO);
                    run_last = err ? TMO : eng_d + 1;
                    resp     = err ? TMO + 1 : eng_d + 3;
                    chk("enable", o_Lfsr_Enable, m_cyc <= run_last);
                    if (m_cyc == resp) begin
                        chk("done", o_Done, m_gnt);
                        chk("error", o_Error, err);
                        chk("result", o_Result, err ? m_last_res : m_exp);
                        if (!err) m_last_res = m_exp;
                        m_last   = m_idx;
                        m_active = 1'b0;
                        m_block  = 1'b1;
                    end else begin
                        chk("done_idle", o_Done, 0);
                        chk("err_idle", o_Error, 0);
                        chk("result_hold", o_Result, m_last_res);
                    end
                end
                m_cyc++;
            end
        end
        m_req_s  = i_Req;
        m_seed_s = i_Seed;
        m_data_s = i_Data;
    end

    // ---------------- stimulus helpers ----------------
    task automatic wait_done(input string tag, input logic [N-1:0] exp, input int budget);
        for (int c = 0; c < budget; c++) begin
            @(posedge clk); #1;
            if (o_Done != 0) break;
        end
        chk(tag, o_Done, exp);
    endtask

    // Present a request in an idle cycle and count cycles until the done pulse shows.
    task automatic run_op(input logic [N-1:0] mask, input int d, output int n);
        @(posedge clk); #1;
        next_d = d;
        i_Req  = mask;
        n      = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (o_Done == 0 && n < TMO + 20);
        i_Req = '0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_grant"}, o_Grant, 0);
        chk({tag, "_done"}, o_Done, 0);
        chk({tag, "_err"}, o_Error, 0);
        chk({tag, "_result"}, o_Result, 0);
        chk({tag, "_busy"}, o_Busy, 0);
        chk({tag, "_en"}, o_Lfsr_Enable, 0);
        chk({tag, "_load"}, o_Lfsr_Load, 0);
        chk({tag, "_seed"}, o_Lfsr_Seed, 0);
        chk({tag, "_data"}, o_Lfsr_Data_In, 0);
    endtask

    int pool [7] = '{1, 2, 7, 30, TMO - 1, TMO, 1 << 20};

    initial begin
        logic [NB-1:0] sa, sb;
        logic [OS-1:0] da, db, exp_b, exp_r;
        logic [N-1:0]  want;
        int            n;
        rst    = 1'b1;
        i_Req  = '0;
        i_Seed = '0;
        i_Data = '0;
        next_d = OS;
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset");
        rst = 1'b0;

        // Single request, seed 1, zero data: result is the bare keystream.
        i_Seed = {32'h0, 32'h1};
        i_Data = '0;
        run_op(2'b01, OS, n);
        chk("a_done", o_Done, 2'b01);
        chk("a_err", o_Error, 0);
        chk("a_result", o_Result, ks(32'h1));
        chk("a_latency", n, OS + 4);
        @(posedge clk); #1;
        chk("a_pulse_width", o_Done, 0);

        // Both held: grants alternate, starting after the last winner (0).
        sa = 32'h1234_5678; sb = 32'h9abc_def1;
        da = rnd_blk();     db = rnd_blk();
        i_Seed = {sb, sa};
        i_Data = {db, da};
        next_d = 20;
        i_Req  = 2'b11;
        want   = 2'b10;
        for (int j = 0; j < 4; j++) begin
            wait_done("b_order", want, 200);
            want = ~want;
        end
        i_Req = '0;
        exp_b = ks(sa) ^ da;
        chk("b_result", o_Result, exp_b);

        // Engine never finishes: abort with error, result untouched.
        run_op(2'b01, 1 << 20, n);
        chk("c_latency", n, TMO + 2);
        chk("c_done", o_Done, 2'b01);
        chk("c_err", o_Error, 1);
        chk("c_result", o_Result, exp_b);

        // Watchdog boundary: done on the last allowed cycle wins; one later aborts.
        exp_r = ks(sb) ^ db;
        for (int b = 0; b < 2; b++) begin
            run_op(2'b10, TMO - 1 + b, n);
            chk("bd_done", o_Done, 2'b10);
            chk("bd_err", o_Error, b);
            chk("bd_result", o_Result, exp_r);
            chk("bd_latency", n, (b != 0) ? TMO + 2 : TMO + 3);
        end

        // Requester 1 drops its request one cycle after the grant.
        @(posedge clk); #1;
        next_d = 40;
        i_Req  = 2'b10;
        for (int c = 0; c < 10 && o_Grant[1] == 1'b0; c++) begin
            @(posedge clk); #1;
        end
        chk("d_grant", o_Grant, 2'b10);
        @(posedge clk); #1;
        i_Req = '0;
        wait_done("d_done", 2'b10, 200);

        // Asynchronous reset in the middle of RUN.
        @(posedge clk); #1;
        next_d = OS;
        i_Req  = 2'b10;
        repeat (60) @(posedge clk);
        #3 rst = 1'b1;
        #1 chk_all_zero("e_reset");
        @(posedge clk); #1;
        i_Req = 2'b11;
        rst   = 1'b0;
        wait_done("e_first", 2'b01, 400);
        i_Req = '0;

        // Random traffic.
        for (int c = 0; c < 6000; c++) begin
            @(posedge clk); #1;
            for (int k = 0; k < N; k++) begin
                if (o_Done[k]) begin
                    if ($urandom_range(1, 0) == 0) i_Req[k] = 1'b0;
                end else if (o_Grant[k] && $urandom_range(63, 0) == 0) begin
                    i_Req[k] = 1'b0;
                end else if (!i_Req[k] && $urandom_range(3, 0) == 0) begin
                    i_Req[k] = 1'b1;
                end
            end
            i_Seed = {$urandom, $urandom};
            i_Data = {rnd_blk(), rnd_blk()};
            next_d = pool[$urandom_range(6, 0)];
        end
        i_Req = '0;
        for (int c = 0; c < 2 * TMO && o_Busy; c++) begin
            @(posedge clk); #1;
        end
        chk("drain_busy", o_Busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
